ysyx_23060171_lsu: RTL
======================

Name: ysyx_23060171_lsu

Overview:
Load/store unit that executes the memory controls the decoder produces: MemValid, MemWriteE, MemWmask and MemRD.
- Accepts one memory operation per upstream handshake.
- Aligns store data and byte strobes to the word address, issues a single request on a valid/ready data-memory bus and waits a variable number of cycles for the response.
- Sign- or zero-extends load data and returns a result to write-back through a valid/ready handshake.
- Sits between EXU (address from ALU result) and WBU.

Parameters:
XLEN, 32, data and address width
TIMEOUT, 255, cycles in RESP before the operation aborts with err

Ports:
clk  in  1  clock
rst_n  in  1  reset
in_valid  in  1  upstream operation valid
in_ready  out  1  LSU can accept an operation
mem_valid  in  1  decoded MemValid; 0 means pass-through (no bus access)
mem_we  in  1  decoded MemWriteE
mem_wmask  in  8  decoded MemWmask: 00000001 byte, 00000011 half, 00001111 word
mem_rd  in  3  decoded MemRD: 000 lb, 001 lh, 010 lw, 011 lbu, 100 lhu
addr  in  XLEN  effective address (ALU result)
wdata  in  XLEN  store data (rs2)
bus_req_valid  out  1  bus request valid
bus_req_ready  in  1  bus accepts request
bus_req_we  out  1  write request
bus_req_addr  out  XLEN  addr with [1:0] forced to 0
bus_req_wdata  out  XLEN  wdata shifted left by 8*addr[1:0]
bus_req_wstrb  out  4  mask[3:0] shifted left by addr[1:0]
bus_resp_valid  in  1  response valid (read data or write ack)
bus_resp_data  in  XLEN  read word
bus_resp_err  in  1  bus error
out_valid  out  1  result valid
out_ready  in  1  downstream accepts result
out_rdata  out  XLEN  extended load data; 0 for stores and pass-through
out_err  out  1  misaligned, bus error or timeout

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low (clk, rst_n).
- Reset values: state IDLE, in_ready=1, bus_req_valid=0, out_valid=0, out_rdata=0, out_err=0, timeout counter=0.
- Capture: in_valid&&in_ready registers all inputs. in_ready is 1 only in IDLE.

State machine:
- IDLE -> DONE when mem_valid=0 (pass-through: out_rdata=0, err=0, one-cycle latency).
- IDLE -> DONE with err=1 when misaligned: half with addr[0]=1, or word with addr[1:0]!=0. No bus request is issued.
- IDLE -> REQ otherwise.
- REQ: bus_req_valid=1 and all bus_req_* stable until bus_req_ready. On handshake -> RESP and clear the counter.
- RESP: counter increments each cycle.
  - bus_resp_valid -> DONE. Capture extended data (reads) and err=bus_resp_err.
  - Counter reaching TIMEOUT -> DONE with err=1, rdata=0.
- DONE: out_valid=1, outputs held stable until out_ready; then -> IDLE. in_ready becomes 1 the cycle after the out handshake.

Load extraction: lane = bus_resp_data >> (8*addr[1:0]).
- lb: sign-extend lane[7:0]; lbu: zero-extend lane[7:0].
- lh: sign-extend lane[15:0]; lhu: zero-extend lane[15:0].
- lw: full word.
- Unknown mem_rd: zero-extend lane[7:0].

Stores: out_rdata=0. mem_rd is ignored; mem_wmask bits [7:4] are ignored.

Boundary rules:
- bus_resp_valid arriving in REQ is ignored (no response before the request is accepted).
- bus_resp_valid in the same cycle the counter hits TIMEOUT: the response wins, so err=bus_resp_err.
- out_ready held high gives back-to-back throughput of 1 op per (3 + bus latency) cycles.
- rst_n low mid-operation: immediate return to reset values. A bus response arriving after reset is ignored in IDLE.

Test Plan:
- sw addr=0x80000004 wdata=0x11223344, ready immediately, resp next cycle -> req addr 0x80000004, wstrb=1111, wdata=0x11223344; out_valid with rdata=0, err=0.
- sb addr=0x80000003 wdata=0x000000AB -> wstrb=1000, wdata=0xAB000000, addr 0x80000000.
- lb addr=0x80000002, resp data 0x12F0_5678 (byte2=0xF0) -> rdata=0xFFFFFFF0. lbu on the same data -> 0x000000F0. lhu addr=0x80000002 -> 0x000012F0.
- lw addr=0x80000006 -> no bus_req_valid, out_err=1, out_valid after 1 cycle.
- lh with bus_req_ready low 5 cycles, resp after 10 more cycles, out_ready low 3 cycles -> request signals stable during the stall, single request, out_* held stable until out_ready.
- No response after the request with TIMEOUT=8 -> err=1 exactly 8 cycles after the request handshake. Separately, rst_n low during RESP -> all outputs return to reset values asynchronously.

Source files
------------

// File: rtl/ysyx_23060171_lsu.sv
// Load/store unit: takes one decoded memory operation per upstream handshake,
// issues at most one request on the data bus, and returns the extended load
// data (or zero for stores and pass-through) to write-back.
module ysyx_23060171_lsu #(
    parameter int unsigned XLEN    = 32,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            i_in_valid,
    output logic            o_in_ready,
    input  logic            i_mem_valid,
    input  logic            i_mem_we,
    input  logic [7:0]      i_mem_wmask,
    input  logic [2:0]      i_mem_rd,
    input  logic [XLEN-1:0] i_addr,
    input  logic [XLEN-1:0] i_wdata,
    output logic            o_bus_req_valid,
    input  logic            i_bus_req_ready,
    output logic            o_bus_req_we,
    output logic [XLEN-1:0] o_bus_req_addr,
    output logic [XLEN-1:0] o_bus_req_wdata,
    output logic [3:0]      o_bus_req_wstrb,
    input  logic            i_bus_resp_valid,
    input  logic [XLEN-1:0] i_bus_resp_data,
    input  logic            i_bus_resp_err,
    output logic            o_out_valid,
    input  logic            i_out_ready,
    output logic [XLEN-1:0] o_out_rdata,
    output logic            o_out_err
);

    localparam int unsigned CW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {StIdle, StReq, StResp, StDone} state_t;

    state_t          r_state, w_state_d;
    logic [CW-1:0]   r_cnt, w_cnt_d, w_cnt_inc;
    logic [XLEN-1:0] r_rdata, w_rdata_d;
    logic            r_err, w_err_d;

    // Operation captured at the upstream handshake.
    logic            r_we;
    logic [3:0]      r_mask;
    logic [2:0]      r_rd;
    logic [XLEN-1:0] r_addr;
    logic [XLEN-1:0] r_wdata;

    logic            w_accept;
    logic            w_is_half;
    logic            w_is_word;
    logic            w_misaligned;
    logic [XLEN-1:0] w_lane;
    logic [XLEN-1:0] w_load;
    logic            w_unused_wmask;

    // Upper mask bits carry no meaning for a 32-bit bus.
    assign w_unused_wmask = ^i_mem_wmask[7:4];

    assign w_accept  = i_in_valid && o_in_ready;
    assign w_cnt_inc = r_cnt + CW'(1);

    // Access size comes from the mask for stores and from MemRD for loads.
    assign w_is_half = i_mem_we ? (i_mem_wmask[3:0] == 4'b0011)
                                : (i_mem_rd == 3'b001 || i_mem_rd == 3'b100);
    assign w_is_word = i_mem_we ? (i_mem_wmask[3:0] == 4'b1111) : (i_mem_rd == 3'b010);
    assign w_misaligned = (w_is_half && i_addr[0]) || (w_is_word && (i_addr[1:0] != 2'b00));

    assign o_in_ready      = (r_state == StIdle);
    assign o_bus_req_valid = (r_state == StReq);
    assign o_bus_req_we    = r_we;
    assign o_bus_req_addr  = {r_addr[XLEN-1:2], 2'b00};
    assign o_bus_req_wdata = r_wdata << {r_addr[1:0], 3'b000};
    assign o_bus_req_wstrb = r_mask << r_addr[1:0];
    assign o_out_valid     = (r_state == StDone);
    assign o_out_rdata     = r_rdata;
    assign o_out_err       = r_err;

    assign w_lane = i_bus_resp_data >> {r_addr[1:0], 3'b000};

    // Select and extend the addressed lane of the read word.
    always_comb begin
        w_load = {{(XLEN-8){1'b0}}, w_lane[7:0]};
        case (r_rd)
            3'b000:  w_load = {{(XLEN-8){w_lane[7]}}, w_lane[7:0]};
            3'b001:  w_load = {{(XLEN-16){w_lane[15]}}, w_lane[15:0]};
            3'b010:  w_load = w_lane;
            3'b100:  w_load = {{(XLEN-16){1'b0}}, w_lane[15:0]};
            default: w_load = {{(XLEN-8){1'b0}}, w_lane[7:0]};
        endcase
    end

    // Next-state, timeout counter and result computation.
    always_comb begin
        w_state_d = r_state;
        w_cnt_d   = r_cnt;
        w_rdata_d = r_rdata;
        w_err_d   = r_err;
        case (r_state)
            StIdle: begin
                if (i_in_valid) begin
                    if (!i_mem_valid || w_misaligned) begin
                        w_state_d = StDone;
                        w_rdata_d = '0;
                        w_err_d   = i_mem_valid;
                    end else begin
                        w_state_d = StReq;
                    end
                end
            end
            StReq: begin
                if (i_bus_req_ready) begin
                    w_state_d = StResp;
                    w_cnt_d   = '0;
                end
            end
            StResp: begin
                w_cnt_d = w_cnt_inc;
                // A response in the timeout cycle still wins.
                if (i_bus_resp_valid) begin
                    w_state_d = StDone;
                    w_rdata_d = r_we ? '0 : w_load;
                    w_err_d   = i_bus_resp_err;
                end else if (w_cnt_inc == CW'(TIMEOUT)) begin
                    w_state_d = StDone;
                    w_rdata_d = '0;
                    w_err_d   = 1'b1;
                end
            end
            StDone: begin
                if (i_out_ready) begin
                    w_state_d = StIdle;
                end
            end
            default: w_state_d = StIdle;
        endcase
    end

    // State, counter and result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= StIdle;
            r_cnt   <= '0;
            r_rdata <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_d;
            r_cnt   <= w_cnt_d;
            r_rdata <= w_rdata_d;
            r_err   <= w_err_d;
        end
    end

    // Operation capture; held stable through REQ so the bus sees fixed values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_we    <= 1'b0;
            r_mask  <= '0;
            r_rd    <= '0;
            r_addr  <= '0;
            r_wdata <= '0;
        end else if (w_accept) begin
            r_we    <= i_mem_we;
            r_mask  <= i_mem_wmask[3:0];
            r_rd    <= i_mem_rd;
            r_addr  <= i_addr;
            r_wdata <= i_wdata;
        end
    end

endmodule
